// File: rtl/usb_rx_pkg.sv
// Shared types for the USB full-speed receive controller: FSM states, error
// causes and the default SYNC pattern.
package usb_rx_pkg;

  localparam logic [7:0] USB_SYNC_DEFAULT = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID_WAIT,
    ST_PID_RCV,
    ST_PID_WRITE,
    ST_PID_CHECK,
    ST_DATA_WAIT,
    ST_DATA_RCV,
    ST_DATA_WRITE,
    ST_EOP,
    ST_ERR,
    ST_ERR_EOP,
    ST_ERR_IDLE
  } rcu_state_t;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_SYNC     = 3'd1,
    E_PID      = 3'd2,
    E_EOP_MID  = 3'd3,
    E_OVERFLOW = 3'd4,
    E_TIMEOUT  = 3'd5
  } rx_err_t;

  // A valid PID carries its own one's complement in the upper nibble.
  function automatic logic pid_ok(input logic [7:0] pid);
    return (pid[7:4] == ~pid[3:0]);
  endfunction

  function automatic logic is_err_state(input rcu_state_t s);
    return (s == ST_ERR) || (s == ST_ERR_EOP) || (s == ST_ERR_IDLE);
  endfunction

endpackage

// File: rtl/rcu_watchdog.sv
// Stall watchdog: down-counter reloaded on clear or while disabled; expires
// once it has counted TIMEOUT_CYC-1 undisturbed cycles.
module rcu_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      cnt <= '0;
    else if (!enable || clear)
      cnt <= LOAD;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/rcu_pkt.sv
// Receive control unit: sequences SYNC, PID, data bytes and EOP for the USB
// full-speed receive path, with sticky error cause and payload byte counter.
module rcu_pkt
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = USB_SYNC_DEFAULT,
  parameter int         MAX_BYTES   = 64,
  parameter int         TIMEOUT_CYC = 64,
  parameter bit         PID_EXT     = 1'b0
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             d_edge,
  input  logic                             shift_en,
  input  logic                             byte_rcvd,
  input  logic                             eop,
  input  logic                             pid_err,
  input  logic [7:0]                       rcv_data,
  output logic                             pid_rst,
  output logic                             pid_set,
  output logic                             rcving,
  output logic                             w_enable,
  output logic                             r_error,
  output logic [2:0]                       err_code,
  output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count,
  output logic                             pkt_done
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  rcu_state_t state, nxt_base, nxt;
  rx_err_t    err_q, err_base, err_in;
  logic [7:0] pid_q;
  logic       bad_pid, timeout, wd_active, wd_clear;

  assign bad_pid = PID_EXT ? pid_err : !pid_ok(pid_q);

  always_comb begin
    nxt_base = state;
    err_base = E_NONE;
    case (state)
      ST_IDLE:       if (d_edge) nxt_base = ST_SYNC;
      ST_SYNC: begin
        if (byte_rcvd) begin
          if (rcv_data == SYNC_BYTE) nxt_base = ST_PID_WAIT;
          else begin nxt_base = ST_ERR; err_base = E_SYNC; end
        end
      end
      ST_PID_WAIT: begin
        if (shift_en) begin
          if (eop) begin nxt_base = ST_ERR_EOP; err_base = E_EOP_MID; end
          else nxt_base = ST_PID_RCV;
        end
      end
      ST_PID_RCV: begin
        if (byte_rcvd) nxt_base = ST_PID_WRITE;
        else if (shift_en && eop) begin nxt_base = ST_ERR_EOP; err_base = E_EOP_MID; end
      end
      ST_PID_WRITE:  nxt_base = ST_PID_CHECK;
      ST_PID_CHECK: begin
        if (bad_pid) begin nxt_base = ST_ERR; err_base = E_PID; end
        else nxt_base = ST_DATA_WAIT;
      end
      ST_DATA_WAIT:  if (shift_en) nxt_base = eop ? ST_EOP : ST_DATA_RCV;
      ST_DATA_RCV: begin
        // EOP beats a byte completing in the same cycle: that byte is partial.
        if (shift_en && eop) begin nxt_base = ST_ERR_EOP; err_base = E_EOP_MID; end
        else if (byte_rcvd) begin
          if (byte_count == BCW'(MAX_BYTES)) begin nxt_base = ST_ERR; err_base = E_OVERFLOW; end
          else nxt_base = ST_DATA_WRITE;
        end
      end
      ST_DATA_WRITE: nxt_base = ST_DATA_WAIT;
      ST_EOP:        if (d_edge) nxt_base = ST_IDLE;
      ST_ERR:        if (shift_en && eop) nxt_base = ST_ERR_EOP;
      ST_ERR_EOP:    if (d_edge) nxt_base = ST_ERR_IDLE;
      ST_ERR_IDLE:   if (d_edge) nxt_base = ST_SYNC;
      default:       nxt_base = ST_IDLE;
    endcase
  end

  assign wd_active = (state inside {ST_SYNC, ST_PID_WAIT, ST_PID_RCV, ST_PID_WRITE,
                                    ST_PID_CHECK, ST_DATA_WAIT, ST_DATA_RCV,
                                    ST_DATA_WRITE, ST_ERR});
  // State-change clear uses the non-timeout next state to avoid a loop.
  assign wd_clear  = shift_en || d_edge || (nxt_base != state);

  rcu_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (wd_clear),
    .enable  (wd_active),
    .expired (timeout)
  );

  assign nxt    = timeout ? ST_ERR_IDLE : nxt_base;
  assign err_in = timeout ? E_TIMEOUT : err_base;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      err_q      <= E_NONE;
      byte_count <= '0;
      pid_q      <= '0;
      pkt_done   <= 1'b0;
    end else begin
      state    <= nxt;
      pkt_done <= (state == ST_DATA_WAIT) && (nxt == ST_EOP);
      if (state == ST_PID_WRITE)
        pid_q <= rcv_data;
      if ((nxt == ST_SYNC) && (state != ST_SYNC))
        err_q <= E_NONE;
      else if (is_err_state(nxt) && !is_err_state(state))
        err_q <= err_in;
      if ((nxt == ST_SYNC) && (state != ST_SYNC))
        byte_count <= '0;
      else if (state == ST_DATA_WRITE)
        byte_count <= byte_count + BCW'(1);
    end
  end

  assign err_code = err_q;
  assign rcving   = !(state inside {ST_IDLE, ST_EOP, ST_ERR_IDLE});
  assign w_enable = (state == ST_DATA_WRITE);
  assign pid_set  = (state == ST_PID_WRITE);
  assign pid_rst  = (state == ST_SYNC);
  assign r_error  = is_err_state(state);

endmodule

// File: doc/rcu_pkt.md
# rcu_pkt

Parametrised receiver control unit for the USB 1.1 full-speed receive path. It sits between the bit-level front end (edge detector, shift timing, 8-bit shift register, EOP detector) and the receive FIFO, and sequences SYNC → PID → data bytes → EOP. It extends the previous receiver controller with:
- a configurable SYNC byte
- internal PID complement checking, with an optional external check
- a bounded payload byte counter with overflow error
- a stall watchdog
- an encoded, sticky error cause and a one-cycle end-of-packet strobe

## Interface
Parameters:
- SYNC_BYTE, 8'h80: value `rcv_data` must equal at the first `byte_rcvd` after the packet starts.
- MAX_BYTES, 64: maximum payload bytes (PID excluded); must be ≥ 1.
- TIMEOUT_CYC, 64: cycles without `shift_en` or `d_edge`, in any receiving state, before a timeout error; must be ≥ 2.
- PID_EXT, 0: 0 = internal check (`rcv_data[7:4] == ~rcv_data[3:0]`); 1 = use the `pid_err` input.

Ports:
- `clk`  in  1  system clock; the only clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `d_edge`  in  1  line transition seen on D+/D−.
- `shift_en`  in  1  bit-sample strobe.
- `byte_rcvd`  in  1  one-cycle pulse: the shift register holds a full byte.
- `eop`  in  1  SE0 currently detected.
- `pid_err`  in  1  external PID error; sampled only when PID_EXT = 1.
- `rcv_data`  in  8  current shift-register byte.
- `pid_rst`  out  1  clear the PID register.
- `pid_set`  out  1  load the PID register from `rcv_data`.
- `rcving`  out  1  packet in progress.
- `w_enable`  out  1  push `rcv_data` into the receive FIFO.
- `r_error`  out  1  error state active.
- `err_code`  out  3  error cause. 0 = none, 1 = bad sync, 2 = bad PID, 3 = EOP mid-byte, 4 = overflow, 5 = timeout.
- `byte_count`  out  $clog2(MAX_BYTES+1)  payload bytes written in the current packet.
- `pkt_done`  out  1  one-cycle pulse: clean packet end.

## Operation
States: IDLE, SYNC, PID_WAIT, PID_RCV, PID_WRITE, PID_CHECK, DATA_WAIT, DATA_RCV, DATA_WRITE, EOP, ERR, ERR_EOP, ERR_IDLE.

Transitions:
- **IDLE**
  - `d_edge` → SYNC.
- **SYNC**
  - `byte_rcvd` with `rcv_data == SYNC_BYTE` → PID_WAIT.
  - `byte_rcvd` with any other value → ERR, code 1.
- **PID_WAIT**
  - `shift_en & ~eop` → PID_RCV.
  - `shift_en & eop` → ERR_EOP, code 3.
- **PID_RCV**
  - `byte_rcvd` → PID_WRITE.
  - Else `shift_en & eop` → ERR_EOP, code 3.
- **PID_WRITE**
  - Always → PID_CHECK.
- **PID_CHECK**
  - PID bad → ERR, code 2.
  - Otherwise → DATA_WAIT.
  - The internal check evaluates the PID byte latched in PID_WRITE.
- **DATA_WAIT**
  - `shift_en & ~eop` → DATA_RCV.
  - `shift_en & eop` → EOP; `pkt_done` fires.
- **DATA_RCV**
  - `shift_en & eop` → ERR_EOP, code 3. This has priority over `byte_rcvd` in the same cycle.
  - Else `byte_rcvd` with `byte_count == MAX_BYTES` → ERR, code 4; no write.
  - Else `byte_rcvd` → DATA_WRITE.
- **DATA_WRITE**
  - Always → DATA_WAIT.
- **EOP**
  - `d_edge` → IDLE.
- **ERR**
  - `shift_en & eop` → ERR_EOP.
- **ERR_EOP**
  - `d_edge` → ERR_IDLE.
- **ERR_IDLE**
  - `d_edge` → SYNC.

Watchdog:
- Active in SYNC through DATA_WRITE, and in ERR.
- Counts cycles; cleared by `shift_en`, by `d_edge`, and on any state change.
- When the count reaches TIMEOUT_CYC−1 while still counting → ERR_IDLE, code 5.
- Timeout has priority over every other transition.

Outputs (Moore, decoded from state):
- `rcving` = 0 in IDLE, EOP and ERR_IDLE; 1 in all other states.
- `w_enable` = 1 in DATA_WRITE.
- `pid_set` = 1 in PID_WRITE.
- `pid_rst` = 1 in SYNC.
- `r_error` = 1 in ERR, ERR_EOP and ERR_IDLE.

`err_code`:
- Registered; loaded on the transition into an error state.
- Holds (sticky) until the next entry into SYNC, which clears it to 0.
- A later error while already in ERR does not overwrite it.

`byte_count`:
- Registered; cleared on entry to SYNC.
- Increments by 1 in each DATA_WRITE cycle; saturates by construction at MAX_BYTES.
- Holds its value through EOP and the error states.

## Timing
- Reset values: state IDLE; `err_code` 0; `byte_count` 0; watchdog 0. All outputs 0.
- `w_enable` rises 1 cycle after the `byte_rcvd` that completes a data byte and lasts exactly 1 cycle.
- `byte_count` shows the incremented value in the cycle after `w_enable`.
- `pid_set` rises 1 cycle after the PID `byte_rcvd`. The PID verdict is acted on 2 cycles after that pulse.
- `pkt_done` is registered: high for exactly the first cycle in EOP.
- `err_code` changes in the same cycle `r_error` first rises.
- Reset asserted mid-packet forces IDLE asynchronously; no `w_enable` or `pkt_done` is emitted.

## Structure
- Package `usb_rx_pkg` holds:
  - the state enum `rcu_state_t`
  - the error enum `rx_err_t` (3-bit)
  - the localparam `USB_SYNC_DEFAULT = 8'h80`
- One sub-module, `rcu_watchdog`: parametrised down-counter with `clear`, `enable` and `expired` ports.
- FSM, counters and output decode live in `rcu_pkt`.

## Test plan
- **Clean packet:** SYNC 8'h80, PID 8'hE1, 3 data bytes, EOP.
  - Exactly 3 `w_enable` pulses.
  - `byte_count` = 3 and one `pkt_done` pulse.
  - `r_error` stays 0.
- **Bad sync byte:** first byte 8'h81 → ERR with `err_code` 1. Then EOP and two `d_edge` → SYNC, where `err_code` clears to 0.
- **Bad PID:** PID byte 8'hE0 with PID_EXT = 0 → `pid_set` pulse, then ERR with `err_code` 2. No `w_enable` follows.
- **Overflow:** MAX_BYTES = 4, send 5 data bytes → 4 writes, then ERR with code 4. `byte_count` holds at 4.
- **EOP mid-byte:** `eop & shift_en` in the same cycle as `byte_rcvd` in DATA_RCV → ERR_EOP with code 3 and no write.
- **Stall:** TIMEOUT_CYC = 8; inputs frozen in DATA_WAIT → ERR_IDLE after 8 idle cycles with code 5. Separately, assert `n_rst` mid-packet → all outputs 0 immediately.
